sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock FIFO built on the team's inferred dual-port BRAM pattern: synchronous write port, synchronous registered read port. It is the generalised successor to the raw BRAM primitive. It adds pointer management, full/empty and programmable almost-full/almost-empty flags, an occupancy count and overflow/underflow error pulses. A P_FWFT parameter selects standard or first-word-fall-through read mode.

Parameters:
P_DEPTH, 1024, number of words; must be a power of 2, >= 4
P_WIDTH, 8, word width in bits; multiple of 8 or 9
P_FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through
P_ALMOST_FULL, 1020, almost_full asserts when count >= this value; range 1..P_DEPTH
P_ALMOST_EMPTY, 4, almost_empty asserts when count <= this value; range 0..P_DEPTH-1

Ports:
clk  in  1  single clock for all logic and storage
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
wr_data  in  P_WIDTH  write word
full  out  1  count == P_DEPTH
almost_full  out  1  count >= P_ALMOST_FULL
overflow  out  1  one-cycle pulse: wr_en while full
rd_en  in  1  read request (standard mode) / pop (FWFT mode)
rd_data  out  P_WIDTH  read word
rd_valid  out  1  rd_data holds a newly read word (standard mode); equals !empty (FWFT mode)
empty  out  1  no word available to the reader
almost_empty  out  1  count <= P_ALMOST_EMPTY
underflow  out  1  one-cycle pulse: rd_en while empty
count  out  clog2(P_DEPTH)+1  words held, including any word in the FWFT output stage

Behaviour:
- Reset is synchronous and active-high. Clock and reset ports are clk and rst. While rst is high at an edge:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - rd_valid = 0, rd_data = 0, overflow = 0, underflow = 0.
  - RAM contents are not cleared.
  - wr_en and rd_en are ignored on that edge. A mid-operation reset discards all stored data.
- All flags and count are registered and update on the same edge as the pointer change they reflect.
- Write is accepted when wr_en && !full: the word is stored at wr_ptr and wr_ptr increments, wrapping modulo P_DEPTH. If full, the write is dropped, wr_ptr holds and overflow pulses on the next edge.
- Standard mode (P_FWFT=0):
  - A read is accepted when rd_en && !empty: RAM is read at rd_ptr, rd_ptr increments, and on the same edge rd_data is updated and rd_valid = 1 for one cycle. Read latency is 1 cycle.
  - If rd_en is high while empty, rd_data holds, rd_valid = 0 and underflow pulses.
  - A write at edge N makes empty = 0 after edge N.
- FWFT mode (P_FWFT=1):
  - Internal prefetch keeps the head word in an output register; rd_data is valid whenever empty = 0.
  - A write into an empty FIFO at edge N: the RAM is read at edge N+1 and the word appears on rd_data with empty = 0 after edge N+2.
  - An rd_en pop when !empty advances to the next word on the following edge, or sets empty if none remain.
  - The count/full capacity is P_DEPTH total, including the output register.
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: the read is accepted, the write is dropped and overflow pulses.
  - Empty: the write is accepted, the read is rejected and underflow pulses. In FWFT mode, the prefetch path treats the fresh word as new and uses the latency above.
- count never exceeds P_DEPTH and never goes below 0. Pointer wrap from P_DEPTH-1 to 0 is seamless.
- Read-during-write to the same RAM address cannot occur, because the empty/full gating prevents it. The RAM is read-first.

Test Plan:
1. P_DEPTH=16, standard mode: write 0x01..0x10 on 16 consecutive cycles -> full=1 after the 16th edge, count=16, almost_full=1 from count>=P_ALMOST_FULL; a 17th write -> overflow pulses for 1 cycle, count stays 16.
2. Same FIFO, then rd_en for 16 cycles -> rd_data sequence 0x01..0x10 with rd_valid=1, each 1 cycle after its rd_en; empty=1 after the last read; a 17th rd_en -> underflow pulse, rd_valid=0.
3. Wrap-around: 10 writes, 10 reads, then 10 more writes and 10 more reads (pointers wrap past 15->0) -> data order preserved, count returns to 0.
4. Simultaneous wr_en/rd_en with count=5 for 20 cycles -> count stays 5 and output order is exact. With a full FIFO -> read accepted, write dropped, overflow=1. With an empty FIFO -> write accepted, underflow=1, count=1.
5. P_FWFT=1: a single write of 0xA5 at edge N -> empty=0 and rd_data=0xA5 after edge N+2 without rd_en; rd_en pop -> empty=1 next edge, count=0.
6. Reset mid-stream with count=7 and both enables high -> the next cycle shows count=0, empty=1, rd_valid=0, rd_data=0, and flags are clear; subsequent writes/reads operate normally from address 0.

Source files
------------

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO over an inferred dual-port RAM with count,
//            almost flags, error pulses and optional first-word-fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int P_DEPTH        = 1024,
    parameter int P_WIDTH        = 8,
    parameter int P_FWFT         = 0,
    parameter int P_ALMOST_FULL  = 1020,
    parameter int P_ALMOST_EMPTY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [P_WIDTH-1:0]       wr_data,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     rd_en,
    output logic [P_WIDTH-1:0]       rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     underflow,
    output logic [$clog2(P_DEPTH):0] count
);

    localparam int c_aw = $clog2(P_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(P_DEPTH);
    localparam logic [c_cw-1:0] c_af    = c_cw'(P_ALMOST_FULL);
    localparam logic [c_cw-1:0] c_ae    = c_cw'(P_ALMOST_EMPTY);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic [c_cw-1:0]    w_count_nxt;
    logic               r_full;
    logic               r_almost_full;
    logic               r_almost_empty;
    logic               r_overflow;
    logic               r_underflow;
    logic               w_wr_acc;
    logic               w_pop;
    logic               w_ram_rd;
    logic               w_empty;

    assign w_wr_acc    = wr_en && !r_full;
    assign w_count_nxt = r_count + c_cw'(w_wr_acc) - c_cw'(w_pop);

    // Storage is never reset; a write during reset is simply not performed.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_depth);
            r_almost_full  <= (w_count_nxt >= c_af);
            r_almost_empty <= (w_count_nxt <= c_ae);
            r_overflow     <= wr_en && r_full;
            r_underflow    <= rd_en && w_empty;
        end
    end

    generate
        if (P_FWFT == 0) begin : g_std
            logic [P_WIDTH-1:0] r_rd_data;
            logic               r_rd_valid;
            logic               r_empty;

            assign w_pop    = rd_en && !r_empty;
            assign w_ram_rd = w_pop;
            assign w_empty  = r_empty;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                    r_empty    <= 1'b1;
                end else begin
                    r_rd_valid <= w_pop;
                    if (w_pop) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                    end
                    r_empty <= (w_count_nxt == '0);
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
            assign empty    = r_empty;
        end else begin : g_fwft
            // Two-stage prefetch: RAM output register (stg) feeding the
            // visible head register (out). Both stages are part of count.
            logic [P_WIDTH-1:0] r_stg_data;
            logic [P_WIDTH-1:0] r_out_data;
            logic               r_stg_vld;
            logic               r_out_vld;
            logic               w_out_load;
            logic               w_ram_has;

            assign w_pop      = rd_en && r_out_vld;
            assign w_out_load = r_stg_vld && (!r_out_vld || w_pop);
            assign w_ram_has  = r_count > (c_cw'(r_stg_vld) + c_cw'(r_out_vld));
            assign w_ram_rd   = w_ram_has && (!r_stg_vld || w_out_load);
            assign w_empty    = !r_out_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stg_data <= '0;
                    r_out_data <= '0;
                    r_stg_vld  <= 1'b0;
                    r_out_vld  <= 1'b0;
                end else begin
                    if (w_ram_rd) begin
                        r_stg_data <= r_mem[r_rd_ptr];
                        r_stg_vld  <= 1'b1;
                    end else if (w_out_load) begin
                        r_stg_vld <= 1'b0;
                    end
                    if (w_out_load) begin
                        r_out_data <= r_stg_data;
                        r_out_vld  <= 1'b1;
                    end else if (w_pop) begin
                        r_out_vld <= 1'b0;
                    end
                end
            end

            assign rd_data  = r_out_data;
            assign rd_valid = r_out_vld;
            assign empty    = !r_out_vld;
        end
    endgenerate

    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Standard and FWFT sync_fifo instances driven by shared stimulus,
//            checked every cycle against queue-based reference models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_depth = 16;
    localparam int c_af    = 14;
    localparam int c_ae    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;

    logic       s_full, s_afull, s_ovf, s_rv, s_empty, s_aempty, s_unf;
    logic [7:0] s_rd_data;
    logic [4:0] s_count;
    logic       f_full, f_afull, f_ovf, f_rv, f_empty, f_aempty, f_unf;
    logic [7:0] f_rd_data;
    logic [4:0] f_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo #(.P_DEPTH(c_depth), .P_WIDTH(8), .P_FWFT(0),
                .P_ALMOST_FULL(c_af), .P_ALMOST_EMPTY(c_ae)) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(s_full), .almost_full(s_afull), .overflow(s_ovf),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rv),
        .empty(s_empty), .almost_empty(s_aempty), .underflow(s_unf),
        .count(s_count)
    );

    sync_fifo #(.P_DEPTH(c_depth), .P_WIDTH(8), .P_FWFT(1),
                .P_ALMOST_FULL(c_af), .P_ALMOST_EMPTY(c_ae)) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .almost_full(f_afull), .overflow(f_ovf),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rv),
        .empty(f_empty), .almost_empty(f_aempty), .underflow(f_unf),
        .count(f_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference models ----------------
    typedef struct packed {
        logic [7:0]  d;
        logic [31:0] e;
    } ent_t;

    logic [7:0]  sq[$];
    logic [7:0]  es_rd;
    logic        es_rv, es_ov, es_un;
    ent_t        fq[$];
    logic        ef_ov, ef_un;
    logic [31:0] edge_n = 0;
    bit          model_ready = 0;

    // A FWFT word is visible two edges after its write, once it is the head.
    function automatic logic f_exp_empty();
        if (fq.size() == 0) return 1'b1;
        return (edge_n < fq[0].e + 2);
    endfunction

    always @(posedge clk) begin
        bit sfull, semp, ffull, femp;
        femp = f_exp_empty();
        edge_n++;
        if (rst) begin
            sq.delete();
            fq.delete();
            es_rd = '0; es_rv = 0; es_ov = 0; es_un = 0;
            ef_ov = 0; ef_un = 0;
            model_ready = 1;
        end else begin
            sfull = (sq.size() == c_depth);
            semp  = (sq.size() == 0);
            es_ov = wr_en && sfull;
            es_un = rd_en && semp;
            es_rv = rd_en && !semp;
            if (es_rv) es_rd = sq.pop_front();
            if (wr_en && !sfull) sq.push_back(wr_data);

            ffull = (fq.size() == c_depth);
            ef_ov = wr_en && ffull;
            ef_un = rd_en && femp;
            if (rd_en && !femp) void'(fq.pop_front());
            if (wr_en && !ffull) fq.push_back('{d: wr_data, e: edge_n});
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            chk("s_count",  32'(s_count), sq.size());
            chk("s_full",   s_full,   sq.size() == c_depth);
            chk("s_afull",  s_afull,  sq.size() >= c_af);
            chk("s_empty",  s_empty,  sq.size() == 0);
            chk("s_aempty", s_aempty, sq.size() <= c_ae);
            chk("s_rd_valid", s_rv,   es_rv);
            chk("s_rd_data", s_rd_data, es_rd);
            chk("s_overflow", s_ovf,  es_ov);
            chk("s_underflow", s_unf, es_un);

            chk("f_count",  32'(f_count), fq.size());
            chk("f_full",   f_full,   fq.size() == c_depth);
            chk("f_afull",  f_afull,  fq.size() >= c_af);
            chk("f_empty",  f_empty,  f_exp_empty());
            chk("f_aempty", f_aempty, fq.size() <= c_ae);
            chk("f_rd_valid", f_rv,   !f_exp_empty());
            chk("f_overflow", f_ovf,  ef_ov);
            chk("f_underflow", f_unf, ef_un);
            if (!f_exp_empty()) chk("f_rd_data", f_rd_data, fq[0].d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned pw;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("lit_reset_count", 32'(s_count), 0);
        chk("lit_reset_empty", s_empty, 1);
        chk("lit_reset_aempty", s_aempty, 1);
        rst = 1'b0;

        // Fill to full, then overflow.
        for (int i = 1; i <= 16; i++) step(1, 0, 8'(i));
        chk("lit_full", s_full, 1);
        chk("lit_full_count", 32'(s_count), 16);
        chk("lit_afull", s_afull, 1);
        step(1, 0, 8'h77);
        chk("lit_overflow", s_ovf, 1);
        chk("lit_ovf_count", 32'(s_count), 16);
        step(0, 0, 0);
        chk("lit_overflow_pulse", s_ovf, 0);

        // Drain in order, then underflow.
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0);
            chk("lit_rd_valid", s_rv, 1);
            chk("lit_rd_data", s_rd_data, 8'(i));
        end
        chk("lit_drained_empty", s_empty, 1);
        step(0, 1, 0);
        chk("lit_underflow", s_unf, 1);
        chk("lit_unf_rd_valid", s_rv, 0);

        // Wrap-around.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h30 + 8'(k * 16 + i)));
            for (int i = 0; i < 10; i++) step(0, 1, 0);
        end
        step(0, 0, 0);
        chk("lit_wrap_count", 32'(s_count), 0);

        // Simultaneous read/write at count 5, when full and when empty.
        for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 20; i++) step(1, 1, 8'($urandom));
        chk("lit_simul_count", 32'(s_count), 5);
        for (int i = 0; i < 11; i++) step(1, 0, 8'($urandom));
        step(1, 1, 8'hEE);
        chk("lit_simul_full_ovf", s_ovf, 1);
        chk("lit_simul_full_count", 32'(s_count), 15);
        for (int i = 0; i < 16; i++) step(0, 1, 0);
        step(1, 1, 8'h5A);
        chk("lit_simul_empty_unf", s_unf, 1);
        chk("lit_simul_empty_count", 32'(s_count), 1);
        step(0, 1, 0);
        chk("lit_simul_empty_data", s_rd_data, 8'h5A);

        // FWFT latency of a single word.
        rst = 1'b1; step(0, 0, 0); rst = 1'b0;
        step(1, 0, 8'hA5);
        chk("lit_fwft_n_empty", f_empty, 1);
        chk("lit_fwft_n_count", 32'(f_count), 1);
        step(0, 0, 0);
        chk("lit_fwft_n1_empty", f_empty, 1);
        step(0, 0, 0);
        chk("lit_fwft_n2_empty", f_empty, 0);
        chk("lit_fwft_n2_data", f_rd_data, 8'hA5);
        step(0, 1, 0);
        chk("lit_fwft_pop_empty", f_empty, 1);
        chk("lit_fwft_pop_count", 32'(f_count), 0);

        // Reset mid-stream with both enables high.
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h60 + 8'(i)));
        step(0, 1, 0);
        step(1, 0, 8'h67);
        rst = 1'b1;
        step(1, 1, 8'h99);
        rst = 1'b0;
        chk("lit_rst_count", 32'(s_count), 0);
        chk("lit_rst_empty", s_empty, 1);
        chk("lit_rst_rd_valid", s_rv, 0);
        chk("lit_rst_rd_data", s_rd_data, 0);
        chk("lit_rst_flags", {s_full, s_afull, s_ovf, s_unf}, 0);
        chk("lit_rst_f_rd_data", f_rd_data, 0);
        step(1, 0, 8'hC3);
        step(0, 1, 0);
        chk("lit_post_rst_data", s_rd_data, 8'hC3);

        // Randomized phases alternating write-heavy and read-heavy traffic.
        for (int i = 0; i < 3000; i++) begin
            pw  = ((i / 250) % 2 == 0) ? 70 : 30;
            rst = ($urandom_range(0, 599) == 0);
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 8'($urandom));
        end
        rst = 1'b0;
        step(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
